// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong game controller.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } pong_state_t;

  localparam int SCREEN_W_DEF    = 640;
  localparam int SCREEN_H_DEF    = 480;
  localparam int BALL_SIZE_DEF   = 8;
  localparam int PADDLE_W_DEF    = 8;
  localparam int PADDLE_H_DEF    = 64;
  localparam int PADDLE_X_L_DEF  = 16;
  localparam int PADDLE_X_R_DEF  = 616;
  localparam int SPEED_DEF       = 2;
  localparam int SERVE_DELAY_DEF = 60;
  localparam int WIN_SCORE_DEF   = 9;

  // Top-left coordinate that centres an object of 'size' within 'span'.
  function automatic int centre(input int span, input int size);
    return span / 2 - size / 2;
  endfunction

  localparam int CX = centre(SCREEN_W_DEF, BALL_SIZE_DEF);
  localparam int CY = centre(SCREEN_H_DEF, BALL_SIZE_DEF);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       dx_r;  // 1: moving right
    logic       dy_d;  // 1: moving down
  } ball_t;

endpackage

// File: rtl/pong_paddle_hit.sv
// Vertical overlap test between the ball and one paddle.
module pong_paddle_hit
  import pong_pkg::*;
#(
  parameter int BALL_SIZE = BALL_SIZE_DEF,
  parameter int PADDLE_H  = PADDLE_H_DEF
) (
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_y,
  output logic       hit
);

  logic [10:0] by, py;

  assign by  = {1'b0, ball_y};
  assign py  = {1'b0, paddle_y};
  assign hit = (by + 11'(BALL_SIZE) > py) && (by < py + 11'(PADDLE_H));

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate pong controller: serve/play/score sequencing and ball motion.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int BALL_SIZE   = BALL_SIZE_DEF,
  parameter int PADDLE_W    = PADDLE_W_DEF,
  parameter int PADDLE_H    = PADDLE_H_DEF,
  parameter int PADDLE_X_L  = PADDLE_X_L_DEF,
  parameter int PADDLE_X_R  = PADDLE_X_R_DEF,
  parameter int SPEED       = SPEED_DEF,
  parameter int SERVE_DELAY = SERVE_DELAY_DEF,
  parameter int WIN_SCORE   = WIN_SCORE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int BALL_CX = centre(SCREEN_W, BALL_SIZE);
  localparam int BALL_CY = centre(SCREEN_H, BALL_SIZE);
  localparam logic [10:0] SPD     = 11'(SPEED);
  localparam logic [10:0] X_MAX   = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_MAX   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] PLANE_R = 11'(PADDLE_X_R - BALL_SIZE);
  localparam logic [10:0] PLANE_L = 11'(PADDLE_X_L + PADDLE_W);
  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam ball_t BALL_RST = '{x: 10'(BALL_CX), y: 10'(BALL_CY), dx_r: 1'b1, dy_d: 1'b1};
  localparam int PAD_L = 0;
  localparam int PAD_R = 1;

  pong_state_t      state_q, state_d;
  ball_t            ball_q, ball_d;
  logic [3:0]       score_l_q, score_l_d, score_r_q, score_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pt_left_q, pt_left_d;

  logic [1:0][9:0]  pad_y;
  logic [1:0]       hit;
  logic [10:0]      bx, by, nx, ny;

  assign pad_y = {paddle_r_y, paddle_l_y};
  assign bx    = {1'b0, ball_q.x};
  assign by    = {1'b0, ball_q.y};

  for (genvar p = 0; p < 2; p++) begin : g_pad
    pong_paddle_hit #(
      .BALL_SIZE (BALL_SIZE),
      .PADDLE_H  (PADDLE_H)
    ) u_hit (
      .ball_y   (ball_q.y),
      .paddle_y (pad_y[p]),
      .hit      (hit[p])
    );
  end

  always_comb begin
    state_d   = state_q;
    ball_d    = ball_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    cnt_d     = cnt_q;
    pt_left_d = pt_left_q;
    nx        = bx;
    ny        = by;
    if (ena) begin
      unique case (state_q)
        ST_IDLE: if (serve) state_d = ST_SERVE_WAIT;
        ST_SERVE_WAIT: begin
          if (frame_tick) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = ST_PLAY;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            if (ball_q.dy_d) begin
              if (by + SPD >= Y_MAX) begin
                ny          = Y_MAX;
                ball_d.dy_d = 1'b0;
              end else begin
                ny = by + SPD;
              end
            end else if (by < SPD) begin
              ny          = '0;
              ball_d.dy_d = 1'b1;
            end else begin
              ny = by - SPD;
            end
            // A miss leaves x where it is; the point is resolved next cycle.
            if (ball_q.dx_r) begin
              if (bx <= PLANE_R && bx + SPD >= PLANE_R && hit[PAD_R]) begin
                nx          = PLANE_R;
                ball_d.dx_r = 1'b0;
              end else if (bx + SPD >= X_MAX) begin
                pt_left_d = 1'b1;
                state_d   = ST_POINT;
              end else begin
                nx = bx + SPD;
              end
            end else begin
              if (bx >= PLANE_L && bx <= PLANE_L + SPD && hit[PAD_L]) begin
                nx          = PLANE_L;
                ball_d.dx_r = 1'b1;
              end else if (bx < SPD) begin
                pt_left_d = 1'b0;
                state_d   = ST_POINT;
              end else begin
                nx = bx - SPD;
              end
            end
            ball_d.x = nx[9:0];
            ball_d.y = ny[9:0];
          end
        end
        ST_POINT: begin
          if (pt_left_q) score_l_d = score_l_q + 4'd1;
          else           score_r_d = score_r_q + 4'd1;
          ball_d.x = BALL_RST.x;
          ball_d.y = BALL_RST.y;
          if ((pt_left_q ? score_l_d : score_r_d) == 4'(WIN_SCORE)) begin
            state_d = ST_GAME_OVER;
          end else begin
            // Next serve heads toward whoever conceded.
            ball_d.dx_r = pt_left_q;
            ball_d.dy_d = ~ball_q.dy_d;
            state_d     = ST_SERVE_WAIT;
          end
        end
        ST_GAME_OVER: begin
          if (serve) begin
            score_l_d = '0;
            score_r_d = '0;
            state_d   = ST_SERVE_WAIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ball_q    <= BALL_RST;
      score_l_q <= '0;
      score_r_q <= '0;
      cnt_q     <= '0;
      pt_left_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ball_q    <= ball_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      cnt_q     <= cnt_d;
      pt_left_q <= pt_left_d;
    end
  end

  assign ball_x    = ball_q.x;
  assign ball_y    = ball_q.y;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = (state_q == ST_GAME_OVER);
  assign state     = state_q;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Frame-rate game controller for `tt_um_PongGame`. It sequences the ball through serve, play and scoring. Once per video frame it advances the ball position, resolves wall and paddle collisions, and maintains both scores. Its `ball_x`/`ball_y` outputs drive the renderer and the `current_ball_x_pos`/`current_ball_y_pos` debug taps.

## Interface
- `SCREEN_W`, default 640: visible width in pixels.
- `SCREEN_H`, default 480: visible height in pixels.
- `BALL_SIZE`, default 8: ball is a square of this side.
- `PADDLE_W`, default 8; `PADDLE_H`, default 64: paddle dimensions.
- `PADDLE_X_L`, default 16; `PADDLE_X_R`, default 616: left x of each paddle.
- `SPEED`, default 2: pixels moved per frame on each axis.
- `SERVE_DELAY`, default 60: frames held at centre before play.
- `WIN_SCORE`, default 9: score that ends the game.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  design enable; low freezes all state.
- `frame_tick`  in  1  one-cycle pulse per frame, at vblank start.
- `serve`  in  1  one-cycle serve/start pulse, already debounced.
- `paddle_l_y`  in  10  top y of the left paddle.
- `paddle_r_y`  in  10  top y of the right paddle.
- `ball_x`  out  10  top-left x of the ball (registered).
- `ball_y`  out  10  top-left y of the ball (registered).
- `score_l`  out  4  left player score.
- `score_r`  out  4  right player score.
- `game_over`  out  1  high while in GAME_OVER.
- `state`  out  3  current FSM state, for debug.

## Operation
- **States:** IDLE, SERVE_WAIT, PLAY, POINT, GAME_OVER.
- **Reset values:** IDLE; ball at centre (CX = SCREEN_W/2 − BALL_SIZE/2 = 316, CY = 236); scores 0; `game_over` 0; dx = +, dy = +; serve counter 0.
- **IDLE:** `serve` → SERVE_WAIT; ball stays at centre.
- **SERVE_WAIT:**
  - Counter increments on each `frame_tick`.
  - When the count reaches SERVE_DELAY, the FSM moves to PLAY and clears the counter. There is no motion on that tick.
- **PLAY:** on each `frame_tick`, the y axis and x axis are updated independently, using the current position.
  - Up: if y < SPEED, then y ← 0 and dy flips to down. Otherwise y −= SPEED.
  - Down: if y + SPEED ≥ SCREEN_H − BALL_SIZE, then y ← SCREEN_H − BALL_SIZE and dy flips. Otherwise y += SPEED.
  - Overlap with a paddle at top P: `ball_y + BALL_SIZE > P` and `ball_y < P + PADDLE_H`.
  - Right, paddle-hit plane: if the ball is at or before the plane, x + SPEED ≥ PADDLE_X_R − BALL_SIZE, and it overlaps the right paddle, then x ← PADDLE_X_R − BALL_SIZE and dx flips.
  - Right, miss: else if x + SPEED ≥ SCREEN_W − BALL_SIZE, the left player scores → POINT.
  - Right, otherwise: x += SPEED.
  - Left mirrors right: paddle-hit plane is PADDLE_X_L + PADDLE_W; miss when x < SPEED; a miss scores for the right player.
  - All comparisons use 11-bit unsigned arithmetic, so there is no wrap.
- **POINT:** one clock cycle.
  - Increment the scorer's count.
  - If the new score equals WIN_SCORE → GAME_OVER. Otherwise recentre the ball, set dx toward the player who conceded, toggle dy, and go to SERVE_WAIT.
- **GAME_OVER:**
  - Ball held at centre; `game_over` = 1.
  - `serve` clears both scores and goes to SERVE_WAIT.
- `serve` is ignored in SERVE_WAIT, PLAY and POINT.
- `ena` = 0: `frame_tick` and `serve` are ignored; all registers hold.

## Timing
- All outputs are registered. The effect of a `frame_tick` is visible on the next rising edge.
- Scoring path: detect (cycle N) → POINT (N+1) → recentred ball and updated score (N+2).
- `frame_tick` and `serve` in the same cycle in IDLE or GAME_OVER: `serve` wins and the tick is dropped.
- `frame_tick` arriving while in POINT is dropped.
- Paddle inputs are sampled only in the cycle `frame_tick` is high.
- Deasserting `rst_n` mid-operation returns everything to reset values immediately, without waiting for `clk`.

## Structure
- `pong_pkg` holds:
  - the state enum `pong_state_t`;
  - the screen and paddle default constants;
  - the derived CX/CY centre constants.
- Sub-module `pong_paddle_hit`: combinational overlap test, instantiated once per paddle. Inputs are ball_y and paddle_y; output is hit.

## Test plan
Benches override SERVE_DELAY = 4.
- **Reset:** pulse `rst_n` low, then send 3 `frame_tick`s → ball stays at (316, 236); scores 0/0; `state` = IDLE.
- **Serve:** `serve`, then 4 ticks → PLAY. The 5th tick → ball at (318, 238).
- **Top wall:** ball at y = 1 moving up, tick → y = 0 and dy = down. Next tick → y = 2.
- **Right paddle hit:** `paddle_r_y` = 200, ball at (606, 230) moving right, tick → x = 608 and dx = left. Next tick → x = 606.
- **Right miss:** `paddle_r_y` = 0, ball at (630, 300) moving right, tick → 2 cycles later `score_l` = 1, ball at (316, 236), state SERVE_WAIT.
- **Game over:** `score_l` = 8, then a left point → `game_over` = 1. A `serve` that coincides with `frame_tick` → scores 0/0, state SERVE_WAIT. With `ena` = 0 during PLAY, 10 ticks leave the ball unchanged.
